// File: rtl/divu_seq.sv
// rtl/divu_seq.sv - sequential unsigned restoring divider built around a small alu
// One trial subtraction per clock; divide-by-zero completes without any RUN cycles.

module alu #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         comp,
  input  logic         ci,
  input  logic [1:0]   f,
  output logic [W-1:0] q,
  output logic         uo,
  output logic         so
);

  logic [W-1:0] bx;
  logic [W-1:0] sum;
  logic         c;

  always_comb begin
    bx       = comp ? ~b : b;
    {c, sum} = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, ci};
    case (f)
      2'b00:   q = sum;
      2'b01:   q = a & bx;
      2'b10:   q = a | bx;
      default: q = a ^ bx;
    endcase
    // In subtract mode the carry is inverted so uo reads as a borrow.
    uo = (f == 2'b00) ? (c ^ comp) : 1'b0;
    so = (f == 2'b00) ? ((a[W-1] == bx[W-1]) && (sum[W-1] != a[W-1])) : 1'b0;
  end

endmodule

module divu_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         dbz
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);
  localparam logic [CW-1:0] ONE        = CW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  psh, qsh, dsh;
  logic [N-1:0]  psh_nxt, qsh_nxt;
  logic [CW-1:0] count;
  logic [N:0]    trial, r;
  logic          uo;
  logic          so_unused;
  logic          r_msb_unused;
  logic          accept;

  assign trial        = {psh, qsh[N-1]};
  assign r_msb_unused = r[N];

  alu #(.W(N + 1)) u_alu (
    .a    (trial),
    .b    ({1'b0, dsh}),
    .comp (1'b1),
    .ci   (1'b1),
    .f    (2'b00),
    .q    (r),
    .uo   (uo),
    .so   (so_unused)
  );

  // Restore on borrow: keep the shifted partial remainder, quotient bit 0.
  assign psh_nxt = uo ? trial[N-1:0] : r[N-1:0];
  assign qsh_nxt = {qsh[N-2:0], ~uo};
  assign accept  = start && (state != RUN);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start)              state_nxt = (divisor != '0) ? RUN : DONE;
        else if (state == DONE) state_nxt = IDLE;
      end
      RUN:     if (count == '0) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      psh       <= '0;
      qsh       <= '0;
      dsh       <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else if (accept) begin
      if (divisor != '0) begin
        psh   <= '0;
        qsh   <= dividend;
        dsh   <= divisor;
        count <= LAST_COUNT;
        dbz   <= 1'b0;
      end else begin
        quotient  <= '1;
        remainder <= dividend;
        dbz       <= 1'b1;
      end
    end else if (state == RUN) begin
      psh   <= psh_nxt;
      qsh   <= qsh_nxt;
      count <= count - ONE;
      if (count == '0) begin
        quotient  <= qsh_nxt;
        remainder <= psh_nxt;
      end
    end
  end

endmodule

// File: tb/tb_divu_seq.sv
// tb/tb_divu_seq.sv - randomized self-checking bench for divu_seq
// Expected results come from plain / and % with the divide-by-zero rule.

module tb_divu_seq;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] dividend, divisor;
  logic         busy, done, dbz;
  logic [N-1:0] quotient, remainder;

  int vectors    = 0;
  int miscompares = 0;

  divu_seq #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] ref_q(input int a, input int b);
    return (b == 0) ? {N{1'b1}} : N'(a / b);
  endfunction

  function automatic logic [N-1:0] ref_r(input int a, input int b);
    return (b == 0) ? N'(a) : N'(a % b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for exactly one edge; returns with cycles=1 right after it.
  task automatic launch(input int a, input int b, output int cycles, output bit saw_busy);
    start    = 1'b1;
    dividend = N'(a);
    divisor  = N'(b);
    tick();
    start    = 1'b0;
    cycles   = 1;
    saw_busy = busy;
  endtask

  task automatic wait_done(inout int cycles, inout bit saw_busy);
    while (!done && cycles < 40) begin
      tick();
      cycles++;
      saw_busy |= busy;
    end
  endtask

  task automatic expect_result(input string tag, input int a, input int b,
                               input int cycles, input bit saw_busy);
    check({tag, " latency"}, cycles, (b == 0) ? 1 : N + 1);
    check({tag, " quotient"}, quotient, ref_q(a, b));
    check({tag, " remainder"}, remainder, ref_r(a, b));
    check({tag, " dbz"}, dbz, (b == 0) ? 1 : 0);
    check({tag, " busy seen"}, saw_busy, (b == 0) ? 0 : 1);
  endtask

  task automatic run_op(input string tag, input int a, input int b);
    int cycles;
    bit saw_busy;
    launch(a, b, cycles, saw_busy);
    wait_done(cycles, saw_busy);
    expect_result(tag, a, b, cycles, saw_busy);
    tick();
    check({tag, " done pulse"}, done, 0);
    check({tag, " hold"}, quotient, ref_q(a, b));
  endtask

  initial begin
    int cycles;
    bit saw_busy;
    bit done_seen;
    int ops;
    int a, b;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset dbz", dbz, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);

    run_op("100/7", 100, 7);
    run_op("255/1", 255, 1);
    run_op("3/200", 3, 200);
    run_op("200/200", 200, 200);
    run_op("5/0", 5, 0);
    run_op("9/3", 9, 3);

    // A request arriving mid-run must be dropped, not queued.
    launch(100, 7, cycles, saw_busy);
    tick(); tick();
    cycles += 2;
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 8'd5;
    tick();
    cycles++;
    start = 1'b0;
    wait_done(cycles, saw_busy);
    expect_result("ignore", 100, 7, cycles, saw_busy);
    tick();
    check("ignore no requeue", busy, 0);

    // Reset mid-run discards the operation.
    launch(100, 7, cycles, saw_busy);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset quotient", quotient, 0);
    check("midreset remainder", remainder, 0);
    check("midreset dbz", dbz, 0);
    done_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      done_seen |= done | busy;
    end
    check("midreset quiet", done_seen, 0);
    run_op("17/4", 17, 4);

    // Back-to-back stream with start held high.
    ops      = 0;
    a        = int'($urandom_range(0, 255));
    b        = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
    start    = 1'b1;
    dividend = N'(a);
    divisor  = N'(b);
    cycles   = 0;
    while (ops < 10000) begin
      tick();
      cycles++;
      if (done) begin
        check("stream latency", cycles, (b == 0) ? 1 : N + 1);
        check("stream quotient", quotient, ref_q(a, b));
        check("stream remainder", remainder, ref_r(a, b));
        check("stream dbz", dbz, (b == 0) ? 1 : 0);
        ops++;
        a        = int'($urandom_range(0, 255));
        b        = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
        dividend = N'(a);
        divisor  = N'(b);
        cycles   = 0;
      end else if (cycles > 20) begin
        check("stream timeout", done, 1);
        break;
      end
    end
    start = 1'b0;
    tick();
    tick();
    check("stream idle", done | busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
